qlab5_nios2_qsys_0_ocimem_arbiter: RTL and testbench

//  Shares the CPU's on-chip debug memory (OCI RAM) between two requesters.
//  - JTAG: sysclk-domain take_action pulses plus jdo from the debug-module wrapper.
//  - Avalon: the CPU-side debug slave.

---
 rtl/qlab5_nios2_qsys_0_ocimem_arbiter_if.sv | 28 ++
 rtl/qlab5_nios2_qsys_0_ocimem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_qlab5_nios2_qsys_0_ocimem_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/qlab5_nios2_qsys_0_ocimem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : qlab5_nios2_qsys_0_ocimem_arbiter_if
// Brief   : Avalon debug-slave bus between the CPU side and the OCI RAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface qlab5_nios2_qsys_0_ocimem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] av_address;
    logic              av_read;
    logic              av_write;
    logic [DATA_W-1:0] av_writedata;
    logic [DATA_W-1:0] av_readdata;
    logic              av_waitrequest;

    modport master (
        output av_address, av_read, av_write, av_writedata,
        input  av_readdata, av_waitrequest
    );

    modport slave (
        input  av_address, av_read, av_write, av_writedata,
        output av_readdata, av_waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/qlab5_nios2_qsys_0_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : qlab5_nios2_qsys_0_ocimem_arbiter
// Brief   : Shares the OCI debug RAM between JTAG and the Avalon debug slave.
// Revision: 1.0 - initial release
// ============================================================================
module qlab5_nios2_qsys_0_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                take_action_ocimem_a,
    input  logic                take_action_ocimem_b,
    input  logic                take_no_action_ocimem_a,
    input  logic [37:0]         jdo,
    qlab5_nios2_qsys_0_ocimem_arbiter_if.slave av,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_we,
    output logic                mem_re,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [ADDR_W-1:0]   MonAReg,
    output logic [DATA_W-1:0]   MonDReg,
    output logic                jtag_busy,
    output logic                jtag_overrun
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_CAP, S_ACK} state_t;
    typedef enum logic [1:0] {OP_A_LOAD, OP_A_READ, OP_B_WRITE, OP_N_READ} jop_t;

    state_t            state, state_nx;
    jop_t              j_op, j_op_nx, live_op, cur_op;
    logic              owner_j, owner_j_nx;
    logic              is_read, is_read_nx;
    logic              last_grant_j, last_grant_j_nx;
    logic              j_pend, j_pend_nx;
    logic [ADDR_W-1:0] j_addr, j_addr_nx, cur_addr;
    logic [DATA_W-1:0] j_wdata, j_wdata_nx, cur_wdata;
    logic [DATA_W-1:0] rd_buf, rd_buf_nx;
    logic [ADDR_W-1:0] mem_addr_nx, mon_a_nx;
    logic [DATA_W-1:0] mem_wdata_nx, mon_d_nx;
    logic              mem_we_nx, mem_re_nx, overrun_nx;
    logic              pulse_any, accept, j_req, av_req, grant_j, grant_av, av_ack;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    assign pulse_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign accept    = pulse_any & ~j_pend;
    assign live_op   = take_action_ocimem_a ? (jdo[35] ? OP_A_READ : OP_A_LOAD)
                     : take_action_ocimem_b ? OP_B_WRITE : OP_N_READ;

    // A freshly accepted pulse is visible to arbitration in its own cycle,
    // so JTAG can win an IDLE that Avalon is also requesting.
    assign j_req     = j_pend | accept;
    assign cur_op    = j_pend ? j_op    : live_op;
    assign cur_addr  = j_pend ? j_addr  : jdo[17 +: ADDR_W];
    assign cur_wdata = j_pend ? j_wdata : jdo[34:3];

    assign av_req    = av.av_read | av.av_write;
    assign grant_j   = (state == S_IDLE) & j_req & (~av_req | ~last_grant_j);
    assign grant_av  = (state == S_IDLE) & av_req & ~grant_j;

    assign av_ack            = (state == S_ACK) & ~owner_j;
    assign av.av_waitrequest = ~av_ack;
    assign av.av_readdata    = av_ack ? rd_buf : '0;
    assign jtag_busy         = j_pend;

    always_comb begin
        state_nx        = state;
        j_op_nx         = j_op;
        owner_j_nx      = owner_j;
        is_read_nx      = is_read;
        last_grant_j_nx = last_grant_j;
        j_pend_nx       = j_pend;
        j_addr_nx       = j_addr;
        j_wdata_nx      = j_wdata;
        rd_buf_nx       = rd_buf;
        mem_addr_nx     = mem_addr;
        mem_wdata_nx    = mem_wdata;
        mem_we_nx       = 1'b0;
        mem_re_nx       = 1'b0;
        mon_a_nx        = MonAReg;
        mon_d_nx        = MonDReg;
        overrun_nx      = jtag_overrun | (pulse_any & j_pend);

        if (accept) begin
            j_pend_nx  = 1'b1;
            j_op_nx    = live_op;
            j_addr_nx  = jdo[17 +: ADDR_W];
            j_wdata_nx = jdo[34:3];
        end

        case (state)
            S_IDLE: begin
                if (grant_j) begin
                    last_grant_j_nx = 1'b1;
                    if (cur_op == OP_A_LOAD) begin
                        // Address-only load: completes here without a memory cycle.
                        mon_a_nx  = cur_addr;
                        j_pend_nx = 1'b0;
                    end else begin
                        owner_j_nx   = 1'b1;
                        is_read_nx   = (cur_op != OP_B_WRITE);
                        mem_addr_nx  = (cur_op == OP_A_READ) ? cur_addr : MonAReg;
                        mem_wdata_nx = cur_wdata;
                        mem_we_nx    = (cur_op == OP_B_WRITE);
                        mem_re_nx    = (cur_op != OP_B_WRITE);
                        if (cur_op == OP_A_READ)
                            mon_a_nx = cur_addr;
                        state_nx     = S_ACC;
                    end
                end else if (grant_av) begin
                    last_grant_j_nx = 1'b0;
                    owner_j_nx      = 1'b0;
                    is_read_nx      = av.av_read;
                    mem_addr_nx     = av.av_address;
                    mem_wdata_nx    = av.av_writedata;
                    mem_we_nx       = av.av_write;
                    mem_re_nx       = av.av_read;
                    state_nx        = S_ACC;
                end
            end
            S_ACC: state_nx = is_read ? S_CAP : S_ACK;
            S_CAP: begin
                rd_buf_nx = mem_rdata;
                state_nx  = S_ACK;
            end
            default: begin
                state_nx = S_IDLE;
                if (owner_j) begin
                    if (is_read)
                        mon_d_nx = rd_buf;
                    // An ocimem_a read steps on from the address it just loaded.
                    mon_a_nx  = MonAReg + ADDR_W'(1);
                    j_pend_nx = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            j_op         <= OP_A_LOAD;
            owner_j      <= 1'b0;
            is_read      <= 1'b0;
            last_grant_j <= 1'b0;
            j_pend       <= 1'b0;
            j_addr       <= '0;
            j_wdata      <= '0;
            rd_buf       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= 1'b0;
            mem_re       <= 1'b0;
            MonAReg      <= '0;
            MonDReg      <= '0;
            jtag_overrun <= 1'b0;
        end else begin
            state        <= state_nx;
            j_op         <= j_op_nx;
            owner_j      <= owner_j_nx;
            is_read      <= is_read_nx;
            last_grant_j <= last_grant_j_nx;
            j_pend       <= j_pend_nx;
            j_addr       <= j_addr_nx;
            j_wdata      <= j_wdata_nx;
            rd_buf       <= rd_buf_nx;
            mem_addr     <= mem_addr_nx;
            mem_wdata    <= mem_wdata_nx;
            mem_we       <= mem_we_nx;
            mem_re       <= mem_re_nx;
            MonAReg      <= mon_a_nx;
            MonDReg      <= mon_d_nx;
            jtag_overrun <= overrun_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qlab5_nios2_qsys_0_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_qlab5_nios2_qsys_0_ocimem_arbiter
// Brief   : Directed self-checking bench for the OCI RAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_qlab5_nios2_qsys_0_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ta_a = 1'b0, ta_b = 1'b0, tna_a = 1'b0;
    logic [37:0] jdo = '0;
    logic [7:0]  mem_addr, MonAReg;
    logic [31:0] mem_wdata, mem_rdata, MonDReg;
    logic        mem_we, mem_re, jtag_busy, jtag_overrun;
    logic [31:0] mem [256];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_acc = 0;

    qlab5_nios2_qsys_0_ocimem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) av_bus ();

    qlab5_nios2_qsys_0_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (ta_a),
        .take_action_ocimem_b    (ta_b),
        .take_no_action_ocimem_a (tna_a),
        .jdo                     (jdo),
        .av                      (av_bus),
        .mem_addr                (mem_addr),
        .mem_wdata               (mem_wdata),
        .mem_we                  (mem_we),
        .mem_re                  (mem_re),
        .mem_rdata               (mem_rdata),
        .MonAReg                 (MonAReg),
        .MonDReg                 (MonDReg),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun)
    );

    always #5 clk = ~clk;

    // OCI RAM model: synchronous write, read data one cycle after mem_re
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we | mem_re) n_acc <= n_acc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic av_xfer(input string tag, input bit wr, input logic [7:0] a,
                           input logic [31:0] wd, input int exp_lat, input logic [31:0] exp_rd);
        int n;
        n = 0;
        av_bus.av_address   = a;
        av_bus.av_writedata = wd;
        av_bus.av_write     = wr;
        av_bus.av_read      = ~wr;
        do begin
            tick();
            n++;
            if (n == 1) begin
                check({tag, "_strobe"}, wr ? mem_we : mem_re, 1);
                check({tag, "_addr"}, mem_addr, a);
            end
        end while (av_bus.av_waitrequest && n < 12);
        check({tag, "_latency"}, n, exp_lat);
        if (!wr) check({tag, "_rdata"}, av_bus.av_readdata, exp_rd);
        av_bus.av_write = 1'b0;
        av_bus.av_read  = 1'b0;
        tick();
        check({tag, "_wait_hi"}, av_bus.av_waitrequest, 1);
    endtask

    task automatic jpulse(input int kind, input logic [37:0] v);
        ta_a  = (kind == 0);
        ta_b  = (kind == 1);
        tna_a = (kind == 2);
        jdo   = v;
        tick();
        ta_a  = 1'b0;
        ta_b  = 1'b0;
        tna_a = 1'b0;
        jdo   = '0;
    endtask

    task automatic wait_jtag(input string tag);
        int n;
        n = 0;
        while (jtag_busy && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, jtag_busy, 0);
    endtask

    function automatic logic [37:0] jdo_addr(input bit rd, input logic [7:0] a);
        logic [37:0] v;
        v = '0;
        v[35] = rd;
        v[24:17] = a;
        return v;
    endfunction

    function automatic logic [37:0] jdo_data(input logic [31:0] d);
        logic [37:0] v;
        v = '0;
        v[34:3] = d;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a0;
        av_bus.av_address   = '0;
        av_bus.av_read      = 1'b0;
        av_bus.av_write     = 1'b0;
        av_bus.av_writedata = '0;
        do_reset();

        check("rst_wait", av_bus.av_waitrequest, 1);
        check("rst_rdata", av_bus.av_readdata, 0);
        check("rst_we", mem_we, 0);
        check("rst_re", mem_re, 0);
        check("rst_mona", MonAReg, 0);
        check("rst_mond", MonDReg, 0);
        check("rst_busy", jtag_busy, 0);
        check("rst_ovr", jtag_overrun, 0);

        // Avalon write then read back
        av_xfer("t1_wr", 1'b1, 8'h10, 32'hDEADBEEF, 2, 32'h0);
        check("t1_wdata_mem", mem[8'h10], 32'hDEADBEEF);
        av_xfer("t2_rd", 1'b0, 8'h10, 32'h0, 3, 32'hDEADBEEF);

        // JTAG sequential reads from 0x05
        for (int i = 0; i < 4; i++)
            av_xfer("t3_fill", 1'b1, 8'(5 + i), 32'hA5A50000 + i, 2, 32'h0);
        jpulse(0, jdo_addr(1'b1, 8'h05));
        wait_jtag("t3_a");
        check("t3_mond0", MonDReg, 32'hA5A50000);
        for (int i = 1; i < 4; i++) begin
            jpulse(2, '0);
            wait_jtag("t3_na");
            check("t3_mond", MonDReg, 32'hA5A50000 + i);
        end
        check("t3_mona_end", MonAReg, 8'h09);

        // Simultaneous JTAG and Avalon from reset: JTAG first, then alternation
        do_reset();
        av_bus.av_address   = 8'h20;
        av_bus.av_writedata = 32'h11112222;
        av_bus.av_write     = 1'b1;
        jpulse(1, jdo_data(32'h33334444));
        check("t4_j_we", mem_we, 1);
        check("t4_j_addr", mem_addr, 8'h00);
        check("t4_j_wdata", mem_wdata, 32'h33334444);
        tick(); tick(); tick();
        check("t4_av_we", mem_we, 1);
        check("t4_av_addr", mem_addr, 8'h20);
        check("t4_av_wait", av_bus.av_waitrequest, 1);
        tick();
        check("t4_av_ack", av_bus.av_waitrequest, 0);
        av_bus.av_address   = 8'h21;
        av_bus.av_writedata = 32'h55556666;
        jpulse(1, jdo_data(32'h77778888));
        check("t4_idle_wait", av_bus.av_waitrequest, 1);
        tick();
        check("t4_j2_addr", mem_addr, 8'h01);
        check("t4_j2_wdata", mem_wdata, 32'h77778888);
        tick(); tick(); tick();
        check("t4_av2_addr", mem_addr, 8'h21);
        tick();
        check("t4_av2_ack", av_bus.av_waitrequest, 0);
        av_bus.av_write = 1'b0;
        tick();
        check("t4_mem0", mem[8'h00], 32'h33334444);
        check("t4_mem1", mem[8'h01], 32'h77778888);
        check("t4_mem20", mem[8'h20], 32'h11112222);
        check("t4_mem21", mem[8'h21], 32'h55556666);

        // Overrun: second pulse while busy is dropped
        a0 = n_acc;
        check("t5_ovr_pre", jtag_overrun, 0);
        jpulse(2, '0);
        check("t5_busy", jtag_busy, 1);
        jpulse(2, '0);
        check("t5_ovr", jtag_overrun, 1);
        wait_jtag("t5_rd");
        check("t5_one_acc", n_acc - a0, 1);
        check("t5_mona", MonAReg, 8'h03);
        a0 = n_acc;
        jpulse(0, jdo_addr(1'b0, 8'hFF));
        wait_jtag("t5_ld");
        check("t5_mona_ff", MonAReg, 8'hFF);
        check("t5_ld_no_acc", n_acc - a0, 0);
        jpulse(1, jdo_data(32'hCAFEF00D));
        wait_jtag("t5_wr");
        check("t5_mem_ff", mem[8'hFF], 32'hCAFEF00D);
        check("t5_mona_wrap", MonAReg, 8'h00);

        // Asynchronous reset during ACC of an Avalon read with JTAG pending
        av_bus.av_address = 8'h10;
        av_bus.av_read    = 1'b1;
        jpulse(2, '0);
        check("t6_re", mem_re, 1);
        check("t6_busy", jtag_busy, 1);
        check("t6_wait", av_bus.av_waitrequest, 1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_re_drop", mem_re, 0);
        check("t6_wait_rst", av_bus.av_waitrequest, 1);
        check("t6_busy_rst", jtag_busy, 0);
        check("t6_ovr_rst", jtag_overrun, 0);
        av_bus.av_read = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("t6_re_idle", mem_re, 0);
        check("t6_wait_idle", av_bus.av_waitrequest, 1);
        av_xfer("t6_post", 1'b0, 8'h10, 32'h0, 3, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
